logic_axi4_stream_skid_buffer: RTL and testbench

Full-throughput, two-entry AXI4-Stream register slice with no combinational path between `tx.tready` and `rx.tready`. It sits directly downstream of the upsizer unit inside the upsizer wrapper. It converts that unit's pipeline-enable style `tx.tready` usage into a fully AXI4-Stream-compliant output. All handshake and payload outputs come from flops.

---
 rtl/logic_axi4_stream_pkg.sv | 37 +++
 rtl/logic_axi4_stream_if.sv | 41 ++++
 rtl/logic_axi4_stream_skid_buffer_payload.sv | 113 +++++++++++
 rtl/logic_axi4_stream_skid_buffer.sv | 128 ++++++++++++
 tb/tb_logic_axi4_stream_skid_buffer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_axi4_stream_pkg.sv
// Shared AXI4-Stream package.
// Holds the skid-buffer occupancy encoding and helpers that size the flat
// payload vector from the stream field configuration.
//   skid_state_t  : EMPTY / HALF / FULL occupancy of the two-slot buffer
//   field_width   : clamps a field width to at least 1 bit for declarations
//   payload_width : total bits of all enabled stream fields
package logic_axi4_stream_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Disabled fields still need a 1-bit declaration to stay legal SV.
    function automatic int unsigned field_width(input int unsigned w);
        return (w > 0) ? w : 1;
    endfunction

    function automatic int unsigned payload_width(
        input int unsigned tdata_bytes,
        input int unsigned tuser_width,
        input int unsigned tdest_width,
        input int unsigned tid_width,
        input bit          use_tlast,
        input bit          use_tkeep,
        input bit          use_tstrb
    );
        int unsigned w;
        w = 8 * tdata_bytes + tuser_width + tdest_width + tid_width;
        if (use_tlast) w += 1;
        if (use_tkeep) w += tdata_bytes;
        if (use_tstrb) w += tdata_bytes;
        return w;
    endfunction

endpackage

// File: rtl/logic_axi4_stream_if.sv
// AXI4-Stream bundle.
// Signals: tvalid, tready, tdata, tkeep, tstrb, tlast, tdest, tid, tuser.
// Zero-width fields are declared 1 bit wide; users decide whether they are
// meaningful.
//   modport rx : block consuming the stream (drives tready)
//   modport tx : block producing the stream (drives everything else)
interface logic_axi4_stream_if
    import logic_axi4_stream_pkg::*;
#(
    parameter int unsigned TDATA_BYTES = 1,
    parameter int unsigned TUSER_WIDTH = 1,
    parameter int unsigned TDEST_WIDTH = 1,
    parameter int unsigned TID_WIDTH   = 1
);
    localparam int unsigned DATA_W = field_width(8 * TDATA_BYTES);
    localparam int unsigned BYTE_W = field_width(TDATA_BYTES);
    localparam int unsigned USER_W = field_width(TUSER_WIDTH);
    localparam int unsigned DEST_W = field_width(TDEST_WIDTH);
    localparam int unsigned ID_W   = field_width(TID_WIDTH);

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [BYTE_W-1:0] tkeep;
    logic [BYTE_W-1:0] tstrb;
    logic              tlast;
    logic [DEST_W-1:0] tdest;
    logic [ID_W-1:0]   tid;
    logic [USER_W-1:0] tuser;

    modport rx (
        input  tvalid, tdata, tkeep, tstrb, tlast, tdest, tid, tuser,
        output tready
    );

    modport tx (
        output tvalid, tdata, tkeep, tstrb, tlast, tdest, tid, tuser,
        input  tready
    );

endinterface

// File: rtl/logic_axi4_stream_skid_buffer_payload.sv
// Pack/unpack between AXI4-Stream fields and one flat payload vector.
// Layout, LSB first: tdata, tkeep, tstrb, tlast, tdest, tid, tuser; only
// enabled fields occupy bits.
//   in_*       : stream fields to pack into pack_vec
//   pack_vec   : packed vector of the in_* fields
//   unpack_vec : packed vector to expand onto out_*
//   out_*      : unpacked fields; disabled ones drive fixed constants
module logic_axi4_stream_skid_buffer_payload
    import logic_axi4_stream_pkg::*;
#(
    parameter int unsigned TDATA_BYTES = 1,
    parameter int unsigned TUSER_WIDTH = 1,
    parameter int unsigned TDEST_WIDTH = 1,
    parameter int unsigned TID_WIDTH   = 1,
    parameter bit          USE_TLAST   = 1,
    parameter bit          USE_TKEEP   = 1,
    parameter bit          USE_TSTRB   = 1,
    localparam int unsigned DATA_W    = field_width(8 * TDATA_BYTES),
    localparam int unsigned BYTE_W    = field_width(TDATA_BYTES),
    localparam int unsigned USER_W    = field_width(TUSER_WIDTH),
    localparam int unsigned DEST_W    = field_width(TDEST_WIDTH),
    localparam int unsigned ID_W      = field_width(TID_WIDTH),
    localparam int unsigned PAYLOAD_W = field_width(payload_width(TDATA_BYTES, TUSER_WIDTH,
                                            TDEST_WIDTH, TID_WIDTH, USE_TLAST, USE_TKEEP, USE_TSTRB))
) (
    input  logic [DATA_W-1:0]    in_tdata,
    input  logic [BYTE_W-1:0]    in_tkeep,
    input  logic [BYTE_W-1:0]    in_tstrb,
    input  logic                 in_tlast,
    input  logic [DEST_W-1:0]    in_tdest,
    input  logic [ID_W-1:0]      in_tid,
    input  logic [USER_W-1:0]    in_tuser,
    output logic [PAYLOAD_W-1:0] pack_vec,
    input  logic [PAYLOAD_W-1:0] unpack_vec,
    output logic [DATA_W-1:0]    out_tdata,
    output logic [BYTE_W-1:0]    out_tkeep,
    output logic [BYTE_W-1:0]    out_tstrb,
    output logic                 out_tlast,
    output logic [DEST_W-1:0]    out_tdest,
    output logic [ID_W-1:0]      out_tid,
    output logic [USER_W-1:0]    out_tuser
);
    localparam int unsigned DW    = 8 * TDATA_BYTES;
    localparam int unsigned KW    = USE_TKEEP ? TDATA_BYTES : 0;
    localparam int unsigned SW    = USE_TSTRB ? TDATA_BYTES : 0;
    localparam int unsigned LW    = USE_TLAST ? 1 : 0;
    localparam int unsigned OFF_K = DW;
    localparam int unsigned OFF_S = OFF_K + KW;
    localparam int unsigned OFF_L = OFF_S + SW;
    localparam int unsigned OFF_D = OFF_L + LW;
    localparam int unsigned OFF_I = OFF_D + TDEST_WIDTH;
    localparam int unsigned OFF_U = OFF_I + TID_WIDTH;
    localparam int unsigned RAW_W = OFF_U + TUSER_WIDTH;

    // Disabled inputs (and the dummy bit of an empty payload) are read here only.
    logic unused_bits;
    assign unused_bits = ^{in_tdata, in_tkeep, in_tstrb, in_tlast, in_tdest,
                           in_tid, in_tuser, unpack_vec};

    if (RAW_W == 0) begin : g_no_payload
        assign pack_vec = '0;
    end

    if (DW > 0) begin : g_data
        assign pack_vec[0 +: DW] = in_tdata;
        assign out_tdata         = unpack_vec[0 +: DW];
    end else begin : g_no_data
        assign out_tdata = '0;
    end

    if (KW > 0) begin : g_keep
        assign pack_vec[OFF_K +: KW] = in_tkeep;
        assign out_tkeep             = unpack_vec[OFF_K +: KW];
    end else begin : g_no_keep
        assign out_tkeep = '1;
    end

    if (SW > 0) begin : g_strb
        assign pack_vec[OFF_S +: SW] = in_tstrb;
        assign out_tstrb             = unpack_vec[OFF_S +: SW];
    end else begin : g_no_strb
        assign out_tstrb = '1;
    end

    if (LW > 0) begin : g_last
        assign pack_vec[OFF_L] = in_tlast;
        assign out_tlast       = unpack_vec[OFF_L];
    end else begin : g_no_last
        assign out_tlast = 1'b1;
    end

    if (TDEST_WIDTH > 0) begin : g_dest
        assign pack_vec[OFF_D +: TDEST_WIDTH] = in_tdest;
        assign out_tdest                      = unpack_vec[OFF_D +: TDEST_WIDTH];
    end else begin : g_no_dest
        assign out_tdest = '0;
    end

    if (TID_WIDTH > 0) begin : g_id
        assign pack_vec[OFF_I +: TID_WIDTH] = in_tid;
        assign out_tid                      = unpack_vec[OFF_I +: TID_WIDTH];
    end else begin : g_no_id
        assign out_tid = '0;
    end

    if (TUSER_WIDTH > 0) begin : g_user
        assign pack_vec[OFF_U +: TUSER_WIDTH] = in_tuser;
        assign out_tuser                      = unpack_vec[OFF_U +: TUSER_WIDTH];
    end else begin : g_no_user
        assign out_tuser = '0;
    end

endmodule

// File: rtl/logic_axi4_stream_skid_buffer.sv
// Two-entry AXI4-Stream register slice (output register + skid register).
// Full throughput with every tx output and rx.tready coming from flops, so
// there is no combinational path from tx.tready to rx.tready.
//   aclk   : clock
//   areset : asynchronous active-high reset (clears control, not payload)
//   rx     : upstream stream (rx modport)
//   tx     : downstream stream (tx modport)
module logic_axi4_stream_skid_buffer
    import logic_axi4_stream_pkg::*;
#(
    parameter int unsigned TDATA_BYTES = 1,
    parameter int unsigned TUSER_WIDTH = 1,
    parameter int unsigned TDEST_WIDTH = 1,
    parameter int unsigned TID_WIDTH   = 1,
    parameter bit          USE_TLAST   = 1,
    parameter bit          USE_TKEEP   = 1,
    parameter bit          USE_TSTRB   = 1
) (
    input logic             aclk,
    input logic             areset,
    logic_axi4_stream_if.rx rx,
    logic_axi4_stream_if.tx tx
);
    localparam int unsigned PAYLOAD_W = field_width(payload_width(TDATA_BYTES, TUSER_WIDTH,
                                            TDEST_WIDTH, TID_WIDTH, USE_TLAST, USE_TKEEP, USE_TSTRB));

    skid_state_t          state_q, state_d;
    logic                 tx_tvalid_q, tx_tvalid_d;
    logic                 rx_tready_q, rx_tready_d;
    logic [PAYLOAD_W-1:0] out_q, out_d;
    logic [PAYLOAD_W-1:0] skid_q, skid_d;
    logic [PAYLOAD_W-1:0] rx_vec;
    logic                 rx_hs, tx_hs;
    logic                 load_out_rx, load_out_skid, load_skid;

    assign rx_hs = rx.tvalid && rx_tready_q;
    assign tx_hs = tx_tvalid_q && tx.tready;

    assign tx.tvalid = tx_tvalid_q;
    assign rx.tready = rx_tready_q;

    logic_axi4_stream_skid_buffer_payload #(
        .TDATA_BYTES (TDATA_BYTES),
        .TUSER_WIDTH (TUSER_WIDTH),
        .TDEST_WIDTH (TDEST_WIDTH),
        .TID_WIDTH   (TID_WIDTH),
        .USE_TLAST   (USE_TLAST),
        .USE_TKEEP   (USE_TKEEP),
        .USE_TSTRB   (USE_TSTRB)
    ) u_payload (
        .in_tdata   (rx.tdata),
        .in_tkeep   (rx.tkeep),
        .in_tstrb   (rx.tstrb),
        .in_tlast   (rx.tlast),
        .in_tdest   (rx.tdest),
        .in_tid     (rx.tid),
        .in_tuser   (rx.tuser),
        .pack_vec   (rx_vec),
        .unpack_vec (out_q),
        .out_tdata  (tx.tdata),
        .out_tkeep  (tx.tkeep),
        .out_tstrb  (tx.tstrb),
        .out_tlast  (tx.tlast),
        .out_tdest  (tx.tdest),
        .out_tid    (tx.tid),
        .out_tuser  (tx.tuser)
    );

    // rx.tready stays low throughout reset; it rises on the first edge after
    // release because the next state then decodes to EMPTY.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= EMPTY;
            tx_tvalid_q <= 1'b0;
            rx_tready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_tvalid_q <= tx_tvalid_d;
            rx_tready_q <= rx_tready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (rx_hs) state_d = HALF;
            HALF: begin
                if (rx_hs && !tx_hs)      state_d = FULL;
                else if (!rx_hs && tx_hs) state_d = EMPTY;
            end
            FULL:    if (tx_hs) state_d = HALF;
            default: state_d = EMPTY;
        endcase
    end

    // Handshake outputs are registered decodes of the next state; the load
    // strobes steer the two payload registers.
    always_comb begin
        tx_tvalid_d   = (state_d != EMPTY);
        rx_tready_d   = (state_d != FULL);
        load_out_rx   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            EMPTY: load_out_rx = rx_hs;
            HALF: begin
                load_out_rx = rx_hs && tx_hs;
                load_skid   = rx_hs && !tx_hs;
            end
            FULL:    load_out_skid = tx_hs;
            default: ;
        endcase
    end

    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        if (load_out_rx)        out_d = rx_vec;
        else if (load_out_skid) out_d = skid_q;
        if (load_skid)          skid_d = rx_vec;
    end

    always_ff @(posedge aclk) begin
        out_q  <= out_d;
        skid_q <= skid_d;
    end

endmodule

// File: tb/tb_logic_axi4_stream_skid_buffer.sv
module tb_logic_axi4_stream_skid_buffer;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  keep;
        logic [1:0]  strb;
        logic        last;
        logic [1:0]  dest;
        logic [3:0]  id;
        logic [2:0]  user;
    } beat_t;

    logic aclk;
    logic areset;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int tx_beats = 0;

    beat_t q1[$];
    beat_t q2[$];

    logic_axi4_stream_if #(.TDATA_BYTES(2), .TUSER_WIDTH(3), .TDEST_WIDTH(2), .TID_WIDTH(4)) rx_if ();
    logic_axi4_stream_if #(.TDATA_BYTES(2), .TUSER_WIDTH(3), .TDEST_WIDTH(2), .TID_WIDTH(4)) tx_if ();
    logic_axi4_stream_if #(.TDATA_BYTES(2), .TUSER_WIDTH(3), .TDEST_WIDTH(2), .TID_WIDTH(0)) rx2_if ();
    logic_axi4_stream_if #(.TDATA_BYTES(2), .TUSER_WIDTH(3), .TDEST_WIDTH(2), .TID_WIDTH(0)) tx2_if ();

    logic_axi4_stream_skid_buffer #(
        .TDATA_BYTES(2), .TUSER_WIDTH(3), .TDEST_WIDTH(2), .TID_WIDTH(4),
        .USE_TLAST(1'b1), .USE_TKEEP(1'b1), .USE_TSTRB(1'b1)
    ) u_dut (
        .aclk   (aclk),
        .areset (areset),
        .rx     (rx_if),
        .tx     (tx_if)
    );

    logic_axi4_stream_skid_buffer #(
        .TDATA_BYTES(2), .TUSER_WIDTH(3), .TDEST_WIDTH(2), .TID_WIDTH(0),
        .USE_TLAST(1'b0), .USE_TKEEP(1'b0), .USE_TSTRB(1'b1)
    ) u_dut2 (
        .aclk   (aclk),
        .areset (areset),
        .rx     (rx2_if),
        .tx     (tx2_if)
    );

    // The reduced build sees the same stream and backpressure.
    assign rx2_if.tvalid = rx_if.tvalid;
    assign rx2_if.tdata  = rx_if.tdata;
    assign rx2_if.tkeep  = rx_if.tkeep;
    assign rx2_if.tstrb  = rx_if.tstrb;
    assign rx2_if.tlast  = rx_if.tlast;
    assign rx2_if.tdest  = rx_if.tdest;
    assign rx2_if.tid    = rx_if.tid[0];
    assign rx2_if.tuser  = rx_if.tuser;
    assign tx2_if.tready = tx_if.tready;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic beat_t cur_tx();
        beat_t r;
        r.data = tx_if.tdata;  r.keep = tx_if.tkeep; r.strb = tx_if.tstrb;
        r.last = tx_if.tlast;  r.dest = tx_if.tdest; r.id   = tx_if.tid;
        r.user = tx_if.tuser;
        return r;
    endfunction

    function automatic beat_t cur_tx2();
        beat_t r;
        r.data = tx2_if.tdata; r.keep = tx2_if.tkeep; r.strb = tx2_if.tstrb;
        r.last = tx2_if.tlast; r.dest = tx2_if.tdest; r.id   = {3'b000, tx2_if.tid};
        r.user = tx2_if.tuser;
        return r;
    endfunction

    function automatic beat_t mk(input logic [15:0] d, input logic l);
        beat_t b;
        b.data = d; b.keep = 2'b11; b.strb = 2'b11; b.last = l;
        b.dest = d[1:0]; b.id = d[3:0] ^ 4'h5; b.user = d[2:0];
        return b;
    endfunction

    // Scoreboard monitor: pops on every output handshake, checks stability while stalled.
    logic  stall1 = 1'b0, stall2 = 1'b0;
    beat_t held1, held2;
    always @(negedge aclk) begin
        if (areset) begin
            stall1 = 1'b0;
            stall2 = 1'b0;
        end else begin
            if (stall1) begin
                chk("stall_tvalid", tx_if.tvalid, 1'b1);
                chk("stall_payload", cur_tx(), held1);
            end
            if (stall2) begin
                chk("stall_tvalid2", tx2_if.tvalid, 1'b1);
                chk("stall_payload2", cur_tx2(), held2);
            end
            if (tx_if.tvalid && tx_if.tready) begin
                tx_beats++;
                if (q1.size() == 0) chk("unexpected_beat", cur_tx(), 64'hx);
                else chk("tx_beat", cur_tx(), q1.pop_front());
            end
            if (tx2_if.tvalid && tx2_if.tready) begin
                if (q2.size() == 0) chk("unexpected_beat2", cur_tx2(), 64'hx);
                else chk("tx_beat2", cur_tx2(), q2.pop_front());
            end
            stall1 = tx_if.tvalid && !tx_if.tready;
            stall2 = tx2_if.tvalid && !tx2_if.tready;
            held1  = cur_tx();
            held2  = cur_tx2();
        end
    end

    task automatic send(input beat_t b, input bit hold);
        beat_t e2;
        bit    done = 1'b0;
        rx_if.tdata = b.data; rx_if.tkeep = b.keep; rx_if.tstrb = b.strb;
        rx_if.tlast = b.last; rx_if.tdest = b.dest; rx_if.tid   = b.id;
        rx_if.tuser = b.user; rx_if.tvalid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge aclk);
            if (rx2_if.tready) begin
                e2 = b; e2.keep = 2'b11; e2.last = 1'b1; e2.id = 4'h0;
                q2.push_back(e2);
            end
            if (rx_if.tready) begin
                q1.push_back(b);
                done = 1'b1;
            end
            @(posedge aclk); #1;
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
        if (!hold) rx_if.tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_if.tvalid = 1'b0;
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    task automatic drain();
        tx_if.tready = 1'b1;
        for (int i = 0; i < 100 && (q1.size() != 0 || q2.size() != 0); i++) @(posedge aclk);
        #1;
        chk("drain_q1", q1.size(), 0);
        chk("drain_q2", q2.size(), 0);
    endtask

    bit    rand_rdy = 1'b0;
    bit    bp_done  = 1'b0;
    beat_t b;
    int    c0, t0;

    initial begin
        areset = 1'b1;
        tx_if.tready = 1'b1;
        b = mk(16'h00A5, 1'b0);
        rx_if.tdata = b.data; rx_if.tkeep = b.keep; rx_if.tstrb = b.strb;
        rx_if.tlast = b.last; rx_if.tdest = b.dest; rx_if.tid = b.id;
        rx_if.tuser = b.user; rx_if.tvalid = 1'b1;

        // Reset release with a beat already waiting.
        repeat (3) @(negedge aclk);
        chk("rst_rx_tready", rx_if.tready, 1'b0);
        chk("rst_tx_tvalid", tx_if.tvalid, 1'b0);
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        chk("rel_rx_tready_before_edge", rx_if.tready, 1'b0);
        chk("rel_tx_tvalid", tx_if.tvalid, 1'b0);
        @(posedge aclk); #1;
        chk("rel_rx_tready_after_edge", rx_if.tready, 1'b1);
        send(b, 1'b0);
        chk("a5_tvalid", tx_if.tvalid, 1'b1);
        chk("a5_tdata", tx_if.tdata, 16'h00A5);
        idle(2);

        // 16 back-to-back beats with tlast on the final one.
        c0 = cyc; t0 = tx_beats;
        for (int i = 0; i < 16; i++) send(mk(16'(i), i == 15), 1'b1);
        chk("stream_cycles", cyc - c0, 16);
        rx_if.tvalid = 1'b0;
        @(negedge aclk); #1;
        chk("stream_beats", tx_beats - t0, 16);
        idle(2);

        // Backpressure into FULL, then release.
        tx_if.tready = 1'b0;
        send(mk(16'h0001, 1'b0), 1'b1);
        send(mk(16'h0002, 1'b0), 1'b1);
        chk("bp_rx_tready_full", rx_if.tready, 1'b0);
        chk("bp_out_beat1", tx_if.tdata, 16'h0001);
        fork
            begin send(mk(16'h0003, 1'b1), 1'b0); bp_done = 1'b1; end
        join_none
        repeat (2) @(negedge aclk);
        chk("bp_rx_tready_wait", rx_if.tready, 1'b0);
        chk("bp_tx_tvalid_wait", tx_if.tvalid, 1'b1);
        @(posedge aclk); #1 tx_if.tready = 1'b1;
        @(posedge aclk); #1;
        chk("bp_no_bubble_rx_tready", rx_if.tready, 1'b1);
        for (int i = 0; i < 50 && !bp_done; i++) @(posedge aclk);
        chk("bp_done", bp_done, 1'b1);
        #1 drain();

        // Random valid/ready, random payload.
        rand_rdy = 1'b1;
        fork
            while (rand_rdy) begin
                @(posedge aclk); #1;
                tx_if.tready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 1000; i++) begin
            b.data = 16'($urandom); b.keep = 2'($urandom); b.strb = 2'($urandom);
            b.last = 1'($urandom);  b.dest = 2'($urandom); b.id   = 4'($urandom);
            b.user = 3'($urandom);
            if ($urandom_range(0, 1) == 1) idle(1);
            send(b, 1'b1);
        end
        rx_if.tvalid = 1'b0;
        rand_rdy = 1'b0;
        repeat (2) @(posedge aclk);
        #1 drain();

        // Reset while FULL discards both buffered beats.
        tx_if.tready = 1'b0;
        send(mk(16'h0011, 1'b0), 1'b1);
        send(mk(16'h0022, 1'b0), 1'b0);
        chk("full_rx_tready", rx_if.tready, 1'b0);
        @(posedge aclk); #2 areset = 1'b1;
        #1;
        chk("async_tx_tvalid", tx_if.tvalid, 1'b0);
        chk("async_rx_tready", rx_if.tready, 1'b0);
        q1.delete();
        q2.delete();
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        tx_if.tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("post_rst_no_stale", tx_if.tvalid, 1'b0);
        end
        @(posedge aclk); #1;
        send(mk(16'h0033, 1'b1), 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
